// File: rtl/seq_detect_pkg.sv
// Shared types, constants and helpers for the parametrised serial pattern detector.
// Contents: default pattern, state-width helper, longest prefix/suffix match function.
// Optional feature macro used by the detector: SEQ_DETECT_MATCH_CNT_EN.
package seq_detect_pkg;

    localparam int unsigned MAX_LEN = 32;
    localparam logic [6:0]  PAT_DEFAULT_7 = 7'b1110010;

    typedef logic [MAX_LEN-1:0] word_t;

    // Bits needed to hold a prefix length in 0..pat_len.
    function automatic int unsigned state_w(input int unsigned pat_len);
        return $clog2(pat_len + 1);
    endfunction

    // Largest k <= min(fill, pat_len) such that the k newest history bits equal
    // the first k pattern bits (pattern MSB-first, right-aligned in pat).
    function automatic int unsigned prefix_match(input word_t       hist,
                                                 input word_t       pat,
                                                 input int unsigned fill,
                                                 input int unsigned pat_len);
        int unsigned best;
        word_t       mask;
        best = 0;
        for (int unsigned k = 1; k <= MAX_LEN; k++) begin
            if (k <= pat_len && k <= fill) begin
                // For k == MAX_LEN the shift yields 0 and the subtraction wraps to all-ones.
                mask = (word_t'(1) << k) - word_t'(1);
                if ((hist & mask) == ((pat >> (pat_len - k)) & mask)) begin
                    best = k;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Bus bundle between the serial front end / control logic and seq_detect_param.
// master: drives in, in_valid, overlap_en, pat_load, pat_data, cnt_clr; sees out, state, match_cnt.
// slave : the detector side of the same signals.
interface seq_detect_param_if #(
    parameter int unsigned PAT_LEN = 7,
    parameter int unsigned CNT_W   = 8
) ();
    import seq_detect_pkg::*;

    localparam int unsigned STATE_W = state_w(PAT_LEN);

    logic               in;
    logic               in_valid;
    logic               overlap_en;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_data;
    logic               cnt_clr;
    logic               out;
    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output in, in_valid, overlap_en, pat_load, pat_data, cnt_clr,
        input  out, state, match_cnt
    );

    modport slave (
        input  in, in_valid, overlap_en, pat_load, pat_data, cnt_clr,
        output out, state, match_cnt
    );

endinterface

// File: rtl/seq_match_cnt.sv
// Saturating match counter with synchronous clear.
// Ports: clk, reset (sync, active-low), inc (count one match), clr (clear, wins over inc),
//        cnt (registered count, sticks at all-ones).
module seq_match_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector with runtime-loadable pattern and
// selectable overlapping / non-overlapping detection.
// Ports: clk, reset (sync, active-low), bus (seq_detect_param_if.slave):
//   in/in_valid serial stream, overlap_en mode, pat_load/pat_data pattern load,
//   cnt_clr counter clear, out match pulse, state matched-prefix length, match_cnt.
// Macro SEQ_DETECT_MATCH_CNT_EN: compiles in the saturating match counter; when
// undefined match_cnt is tied to 0 and cnt_clr is ignored.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned        PAT_LEN     = 7,
    parameter logic [PAT_LEN-1:0] PAT_DEFAULT = PAT_LEN'(PAT_DEFAULT_7),
    parameter int unsigned        CNT_W       = 8
) (
    input logic                clk,
    input logic                reset,
    seq_detect_param_if.slave  bus
);

    localparam int unsigned STATE_W = state_w(PAT_LEN);

    logic [PAT_LEN-1:0] pat_q;
    logic [PAT_LEN-1:0] hist_q;
    logic [STATE_W-1:0] fill_q;
    logic [STATE_W-1:0] state_q;
    logic               out_q;

    logic [PAT_LEN-1:0] hist_nx;
    logic [STATE_W-1:0] fill_nx;
    logic [STATE_W-1:0] state_nx;
    logic               accept_c;
    logic               match_c;

    // Candidate history/fill for an accepted bit and the resulting matched-prefix length.
    always_comb begin
        hist_nx  = {hist_q[PAT_LEN-2:0], bus.in};
        fill_nx  = (fill_q == STATE_W'(PAT_LEN)) ? fill_q : fill_q + STATE_W'(1);
        // Non-overlapping: after a full match only the new bit may start a match.
        if (state_q == STATE_W'(PAT_LEN) && !bus.overlap_en) begin
            fill_nx = STATE_W'(1);
        end
        state_nx = STATE_W'(prefix_match(MAX_LEN'(hist_nx), MAX_LEN'(pat_q),
                                         32'(fill_nx), PAT_LEN));
        accept_c = bus.in_valid && !bus.pat_load;
        match_c  = accept_c && (state_nx == STATE_W'(PAT_LEN));
    end

    // Pattern, history and matched-prefix state; load clears progress but keeps history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pat_q   <= PAT_DEFAULT;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= '0;
            out_q   <= 1'b0;
        end else if (bus.pat_load) begin
            pat_q   <= bus.pat_data;
            fill_q  <= '0;
            state_q <= '0;
            out_q   <= 1'b0;
        end else if (bus.in_valid) begin
            hist_q  <= hist_nx;
            fill_q  <= fill_nx;
            state_q <= state_nx;
            out_q   <= match_c;
        end else begin
            out_q   <= 1'b0;
        end
    end

    assign bus.out   = out_q;
    assign bus.state = state_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_c),
        .clr   (bus.cnt_clr),
        .cnt   (bus.match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = bus.cnt_clr;
    assign bus.match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param plus a standalone narrow
// seq_match_cnt for saturation and clear-priority checks.
module tb_seq_detect_param;
    import seq_detect_pkg::*;

`ifdef SEQ_DETECT_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cnt_exp;

    logic       c_inc;
    logic       c_clr;
    logic [1:0] c_cnt;

    seq_detect_param_if #(.PAT_LEN(7), .CNT_W(8)) bus ();

    seq_detect_param #(
        .PAT_LEN     (7),
        .PAT_DEFAULT (7'b1110010),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    seq_match_cnt #(.CNT_W(2)) u_cnt2 (
        .clk   (clk),
        .reset (reset),
        .inc   (c_inc),
        .clr   (c_clr),
        .cnt   (c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk(tag, 32'(bus.match_cnt), CNT_ON ? 32'(cnt_exp) : 32'd0);
    endtask

    // One accepted bit, then check state and out after the edge.
    task automatic send(input logic b, input int exp_state, input logic exp_out, input string tag);
        bus.in       = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk({tag, ".state"}, 32'(bus.state), 32'(exp_state));
        chk({tag, ".out"}, 32'(bus.out), 32'(exp_out));
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [6:0] p, input string tag);
        bus.pat_data = p;
        bus.pat_load = 1'b1;
        bus.in       = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.pat_load = 1'b0;
        bus.in_valid = 1'b0;
        chk({tag, ".state"}, 32'(bus.state), 32'd0);
        chk({tag, ".out"}, 32'(bus.out), 32'd0);
    endtask

    task automatic cnt_pulse(input logic inc, input logic clr, input logic [1:0] exp, input string tag);
        c_inc = inc;
        c_clr = clr;
        @(posedge clk);
        #1;
        c_inc = 1'b0;
        c_clr = 1'b0;
        chk(tag, 32'(c_cnt), 32'(exp));
    endtask

    initial begin
        logic [6:0]  p_a;
        logic [9:0]  p_alt;
        int          st_ov [10];
        int          st_nov[10];
        n_tests = 0;
        n_fail  = 0;
        cnt_exp = 0;
        reset   = 1'b0;
        c_inc   = 1'b0;
        c_clr   = 1'b0;
        bus.in         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.overlap_en = 1'b1;
        bus.pat_load   = 1'b0;
        bus.pat_data   = '0;
        bus.cnt_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst.state", 32'(bus.state), 32'd0);
        chk("rst.out", 32'(bus.out), 32'd0);
        chk_cnt("rst.cnt");
        chk("rst.cnt2", 32'(c_cnt), 32'd0);

        // Default pattern 1110010 from reset.
        p_a = 7'b1110010;
        for (int i = 0; i < 7; i++) send(p_a[6-i], i + 1, (i == 6), "t1");
        cnt_exp = 1;
        chk_cnt("t1.cnt");
        idle_cycle();
        chk("t1.idle.out", 32'(bus.out), 32'd0);
        chk("t1.idle.state", 32'(bus.state), 32'd7);

        // 11110010: extra leading 1 keeps state at 3.
        load(7'b1110010, "t2.load");
        send(1'b1, 1, 1'b0, "t2.b1");
        send(1'b1, 2, 1'b0, "t2.b2");
        send(1'b1, 3, 1'b0, "t2.b3");
        send(1'b1, 3, 1'b0, "t2.b4");
        send(1'b0, 4, 1'b0, "t2.b5");
        send(1'b0, 5, 1'b0, "t2.b6");
        send(1'b1, 6, 1'b0, "t2.b7");
        send(1'b0, 7, 1'b1, "t2.b8");
        cnt_exp = 2;
        chk_cnt("t2.cnt");

        // Periodic pattern 1010101 on 1010101010, overlapping then non-overlapping.
        p_alt  = 10'b1010101010;
        st_ov  = '{1, 2, 3, 4, 5, 6, 7, 6, 7, 6};
        st_nov = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
        load(7'b1010101, "t3.load");
        for (int i = 0; i < 10; i++) send(p_alt[9-i], st_ov[i], (i == 6 || i == 8), "t3.ov");
        cnt_exp = 4;
        chk_cnt("t3.ov.cnt");
        bus.overlap_en = 1'b0;
        load(7'b1010101, "t3.reload");
        for (int i = 0; i < 10; i++) send(p_alt[9-i], st_nov[i], (i == 6), "t3.nov");
        cnt_exp = 5;
        chk_cnt("t3.nov.cnt");
        bus.overlap_en = 1'b1;

        // in_valid low between every bit: state holds, single pulse.
        load(7'b1110010, "t4.load");
        for (int i = 0; i < 7; i++) begin
            send(p_a[6-i], i + 1, (i == 6), "t4.bit");
            idle_cycle();
            chk("t4.gap.state", 32'(bus.state), 32'(i + 1));
            chk("t4.gap.out", 32'(bus.out), 32'd0);
        end
        cnt_exp = 6;
        chk_cnt("t4.cnt");

        // cnt_clr in the same cycle as a match wins.
        load(7'b1110010, "t5.load");
        for (int i = 0; i < 6; i++) send(p_a[6-i], i + 1, 1'b0, "t5.bit");
        bus.cnt_clr = 1'b1;
        send(1'b0, 7, 1'b1, "t5.last");
        bus.cnt_clr = 1'b0;
        cnt_exp = 0;
        chk_cnt("t5.clr.cnt");
        idle_cycle();
        chk_cnt("t5.after.cnt");

        // Mid-pattern reset restores the default pattern and clears everything.
        load(7'b1110000, "t6.load");
        send(1'b1, 1, 1'b0, "t6.pre");
        send(1'b1, 2, 1'b0, "t6.pre");
        send(1'b1, 3, 1'b0, "t6.pre");
        bus.overlap_en = 1'b0;
        c_inc = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        c_inc = 1'b0;
        bus.overlap_en = 1'b1;
        chk("t6.rst.state", 32'(bus.state), 32'd0);
        chk("t6.rst.out", 32'(bus.out), 32'd0);
        chk_cnt("t6.rst.cnt");
        chk("t6.rst.cnt2", 32'(c_cnt), 32'd0);
        for (int i = 0; i < 7; i++) send(p_a[6-i], i + 1, (i == 6), "t6.bit");
        cnt_exp = 1;
        chk_cnt("t6.cnt");

        // Narrow counter saturates at 3; clear beats increment.
        cnt_pulse(1'b1, 1'b0, 2'd1, "cnt2.inc1");
        cnt_pulse(1'b1, 1'b0, 2'd2, "cnt2.inc2");
        cnt_pulse(1'b1, 1'b0, 2'd3, "cnt2.inc3");
        cnt_pulse(1'b1, 1'b0, 2'd3, "cnt2.sat");
        cnt_pulse(1'b0, 1'b0, 2'd3, "cnt2.hold");
        cnt_pulse(1'b1, 1'b1, 2'd0, "cnt2.clr");
        cnt_pulse(1'b1, 1'b0, 2'd1, "cnt2.reinc");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
